// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core with combinational instruction fetch and byte-addressed data port.
module rv32i_core #(
    parameter int DATA_W     = 32,
    parameter int PC_WIDTH   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instruction,
    output logic [PC_WIDTH-1:0]   pc,
    input  logic [DATA_W-1:0]     d_in,
    output logic                  wr_en,
    output logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_W-1:0]     d_out
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_plus4, jalr_tgt;
    logic [DATA_W-1:0]     rf_q [32];
    logic [6:0]            opcode, f7;
    logic [4:0]            rd, rs1, rs2, shamt;
    logic [2:0]            f3;
    logic [DATA_W-1:0]     imm_i, imm_u, rs1_v, rs2_v, alu_b, alu, ld, rd_wdata;
    logic [PC_WIDTH-1:0]   imm_b, imm_j;
    logic [ADDR_WIDTH-1:0] imm_s, ea;
    logic                  eq, lt, ltu, taken, sub, rd_we, store, imm_ok, reg_ok;

    assign opcode   = instruction[6:0];
    assign rd       = instruction[11:7];
    assign f3       = instruction[14:12];
    assign rs1      = instruction[19:15];
    assign rs2      = instruction[24:20];
    assign f7       = instruction[31:25];
    assign imm_i    = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_u    = {instruction[31:12], 12'b0};
    assign imm_s    = ADDR_WIDTH'({{20{instruction[31]}}, instruction[31:25], instruction[11:7]});
    assign imm_b    = PC_WIDTH'({{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0});
    assign imm_j    = PC_WIDTH'({{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0});
    assign rs1_v    = rf_q[rs1];
    assign rs2_v    = rf_q[rs2];
    assign alu_b    = (opcode == OP_REG || opcode == OP_BRANCH) ? rs2_v : imm_i;
    assign shamt    = alu_b[4:0];
    assign sub      = opcode == OP_REG && f7[5];
    assign eq       = rs1_v == alu_b;
    assign lt       = $signed(rs1_v) < $signed(alu_b);
    assign ltu      = rs1_v < alu_b;
    assign taken    = f3[0] ^ (f3[2] ? (f3[1] ? ltu : lt) : eq);
    assign imm_ok   = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    assign reg_ok   = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    assign pc_plus4 = pc_q + PC_WIDTH'(4);
    assign jalr_tgt = rs1_v[PC_WIDTH-1:0] + imm_i[PC_WIDTH-1:0];
    // Truncated sum equals the low bits of the full 32-bit address sum.
    assign ea       = rs1_v[ADDR_WIDTH-1:0] + (opcode == OP_STORE ? imm_s : imm_i[ADDR_WIDTH-1:0]);
    assign ld       = f3 == 3'd0 ? {{24{d_in[7]}}, d_in[7:0]} :
                      f3 == 3'd1 ? {{16{d_in[15]}}, d_in[15:0]} :
                      f3 == 3'd4 ? {24'b0, d_in[7:0]} :
                      f3 == 3'd5 ? {16'b0, d_in[15:0]} : d_in;

    always_comb begin
        case (f3)
            3'd0:    alu = sub ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1:    alu = rs1_v << shamt;
            3'd2:    alu = DATA_W'(lt);
            3'd3:    alu = DATA_W'(ltu);
            3'd4:    alu = rs1_v ^ alu_b;
            3'd5:    alu = f7[5] ? DATA_W'($signed(rs1_v) >>> shamt) : rs1_v >> shamt;
            3'd6:    alu = rs1_v | alu_b;
            default: alu = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        pc_d     = pc_plus4;
        rd_we    = 1'b0;
        rd_wdata = alu;
        store    = 1'b0;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_wdata = imm_u; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_wdata = DATA_W'(pc_q) + imm_u; end
            OP_JAL:    begin rd_we = 1'b1; rd_wdata = DATA_W'(pc_plus4); pc_d = pc_q + imm_j; end
            OP_JALR:   if (f3 == 3'd0) begin rd_we = 1'b1; rd_wdata = DATA_W'(pc_plus4); pc_d = jalr_tgt & ~PC_WIDTH'(1); end
            OP_BRANCH: if (f3[2:1] != 2'b01 && taken) pc_d = pc_q + imm_b;
            OP_LOAD:   begin rd_we = f3 != 3'd3 && f3[2:1] != 2'b11; rd_wdata = ld; end
            OP_STORE:  store = !f3[2] && f3[1:0] != 2'b11;
            OP_IMM:    rd_we = imm_ok;
            OP_REG:    rd_we = reg_ok;
            default:   ;
        endcase
        rd_we = rd_we && rd != 5'd0;
    end

    assign pc      = pc_q;
    assign wr_en   = store && !rst;
    assign mode    = f3[1:0] == 2'b11 ? 2'd2 : f3[1:0];
    assign wr_addr = ea;
    assign rd_addr = ea;
    assign d_out   = rs2_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_WIDTH'(RESET_PC);
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (rd_we) rf_q[rd] <= rd_wdata;
        end
    end
endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed programs against behavioural instruction/data memories.
module tb_rv32i_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction, d_in, d_out;
    logic [7:0]  pc, wr_addr, rd_addr;
    logic        wr_en;
    logic [1:0]  mode;
    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    logic [63:0] visited;
    int          errors = 0;
    int          checks = 0;
    int          cyc;

    always #5 clk = ~clk;

    rv32i_core dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .d_in(d_in),
        .wr_en(wr_en), .mode(mode), .wr_addr(wr_addr), .rd_addr(rd_addr), .d_out(d_out)
    );

    assign instruction = imem[pc[7:2]];
    assign d_in = {dmem[rd_addr + 8'd3], dmem[rd_addr + 8'd2], dmem[rd_addr + 8'd1], dmem[rd_addr]};

    always @(posedge clk)
        if (wr_en)
            for (int k = 0; k < (mode == 2'd0 ? 1 : mode == 2'd1 ? 2 : 4); k++)
                dmem[wr_addr + 8'(k)] = d_out[8*k +: 8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd32(input logic [7:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = dmem[a + 8'(k)];
        return w;
    endfunction

    function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor;
        visited[pc[7:2]] = 1'b1;
        case (pc)
            8'h00: begin chk("lb_rd_addr", rd_addr, 32'h10); chk("lb_mode", mode, 0); end
            8'h04: begin chk("sw1_wr_en", wr_en, 1); chk("sw1_addr", wr_addr, 32'h40); end
            8'h18: begin chk("lhu_rd_addr", rd_addr, 32'h14); chk("lhu_mode", mode, 1); end
            8'hA8: begin
                chk("sb_wr_en", wr_en, 1); chk("sb_mode", mode, 0);
                chk("sb_addr", wr_addr, 32'h20); chk("sb_dout", d_out, 32'h12345678);
            end
            8'hC4: chk("ecall_wr_en", wr_en, 0);
            default: ;
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h13;
        for (int i = 0; i < 256; i++) dmem[i] = 8'hAA;
        imem[0] = i_t(1, 0, 0, 1, 7'h13);
        imem[1] = s_t(8, 1, 0, 2);
        imem[2] = j_t(0, 0);
        rst = 1'b1;
        repeat (5) begin
            step;
            chk("rst_pc", pc, 0);
            chk("rst_wr_en", wr_en, 0);
        end
        rst = 1'b0;
        #1;
        chk("addi_wr_en", wr_en, 0);
        step;
        chk("pc_after_first", pc, 4);
        chk("sw_wr_en", wr_en, 1);
        chk("sw_mode", mode, 2);
        chk("sw_addr", wr_addr, 8);
        chk("sw_dout", d_out, 1);
        step;
        chk("sw_mem", rd32(8'h08), 1);
        chk("loop_pc", pc, 8);
        repeat (20) step;
        chk("halt_pc", pc, 8);
        chk("halt_wr_en", wr_en, 0);
        chk("halt_mem", rd32(8'h08), 1);
        imem[2] = s_t(8, 1, 0, 2);
        #1;
        chk("pre_rst_store", wr_en, 1);
        rst = 1'b1;
        #1;
        chk("rst_gates_wr_en", wr_en, 0);

        for (int i = 0; i < 64; i++) imem[i] = j_t(0, 0);
        for (int i = 0; i < 256; i++) dmem[i] = 8'hAA;
        dmem[8'h10] = 8'h80;
        dmem[8'h14] = 8'hFF; dmem[8'h15] = 8'hFF; dmem[8'h16] = 8'h01; dmem[8'h17] = 8'h80;
        dmem[8'h20] = 8'h11; dmem[8'h21] = 8'h22; dmem[8'h22] = 8'h33; dmem[8'h23] = 8'h44;
        imem[0]  = i_t(16, 0, 0, 1, 7'h03);        imem[1]  = s_t(64, 1, 0, 2);
        imem[2]  = i_t(16, 0, 4, 2, 7'h03);        imem[3]  = s_t(68, 2, 0, 2);
        imem[4]  = i_t(20, 0, 1, 3, 7'h03);        imem[5]  = s_t(72, 3, 0, 2);
        imem[6]  = i_t(20, 0, 5, 4, 7'h03);        imem[7]  = s_t(76, 4, 0, 2);
        imem[8]  = j_t(8, 5);                      imem[9]  = i_t(32'h77, 0, 0, 5, 7'h13);
        imem[10] = s_t(80, 5, 0, 2);               imem[11] = i_t(5, 0, 0, 6, 7'h13);
        imem[12] = i_t(7, 0, 0, 7, 7'h13);         imem[13] = r_t(7'h20, 7, 6, 0, 8);
        imem[14] = s_t(84, 8, 0, 2);               imem[15] = u_t(20'h80000, 9, 7'h37);
        imem[16] = i_t(32'h404, 9, 5, 10, 7'h13);  imem[17] = s_t(88, 10, 0, 2);
        imem[18] = i_t(4, 9, 5, 11, 7'h13);        imem[19] = s_t(92, 11, 0, 2);
        imem[20] = i_t(-1, 0, 0, 12, 7'h13);       imem[21] = i_t(0, 12, 2, 13, 7'h13);
        imem[22] = s_t(96, 13, 0, 2);              imem[23] = i_t(0, 12, 3, 14, 7'h13);
        imem[24] = s_t(100, 14, 0, 2);             imem[25] = b_t(8, 6, 6, 0);
        imem[26] = i_t(1, 0, 0, 15, 7'h13);        imem[27] = b_t(8, 6, 6, 1);
        imem[28] = i_t(2, 0, 0, 16, 7'h13);        imem[29] = i_t(1, 0, 0, 17, 7'h13);
        imem[30] = b_t(8, 12, 17, 4);              imem[31] = i_t(4, 15, 0, 15, 7'h13);
        imem[32] = b_t(8, 12, 17, 6);              imem[33] = i_t(8, 16, 0, 16, 7'h13);
        imem[34] = s_t(104, 15, 0, 2);             imem[35] = s_t(108, 16, 0, 2);
        imem[36] = i_t(32'h9D, 0, 0, 18, 7'h13);   imem[37] = i_t(0, 18, 0, 19, 7'h67);
        imem[38] = i_t(32'h33, 0, 0, 19, 7'h13);   imem[39] = s_t(112, 19, 0, 2);
        imem[40] = u_t(20'h12345, 20, 7'h37);      imem[41] = i_t(32'h678, 20, 0, 20, 7'h13);
        imem[42] = s_t(32, 20, 0, 0);              imem[43] = i_t(5, 0, 0, 0, 7'h13);
        imem[44] = s_t(116, 0, 0, 2);              imem[45] = u_t(20'h00001, 21, 7'h17);
        imem[46] = s_t(120, 21, 0, 2);             imem[47] = r_t(7'h00, 6, 17, 1, 22);
        imem[48] = s_t(124, 22, 0, 2);             imem[49] = 32'h00000073;
        imem[50] = j_t(0, 0);
        visited = '0;
        step;
        step;
        chk("rst2_pc", pc, 0);
        rst = 1'b0;
        #1;
        cyc = 0;
        while (pc != 8'hC8 && cyc < 150) begin
            monitor;
            step;
            cyc++;
        end
        chk("prog2_end_pc", pc, 32'hC8);
        repeat (5) step;
        chk("prog2_hold_pc", pc, 32'hC8);
        chk("lb", rd32(8'h40), 32'hFFFFFF80);
        chk("lbu", rd32(8'h44), 32'h00000080);
        chk("lh", rd32(8'h48), 32'hFFFFFFFF);
        chk("lhu", rd32(8'h4C), 32'h0000FFFF);
        chk("jal_link", rd32(8'h50), 32'h00000024);
        chk("sub", rd32(8'h54), 32'hFFFFFFFE);
        chk("srai", rd32(8'h58), 32'hF8000000);
        chk("srli", rd32(8'h5C), 32'h08000000);
        chk("slti", rd32(8'h60), 32'h00000001);
        chk("sltiu", rd32(8'h64), 32'h00000000);
        chk("skipped_paths", rd32(8'h68), 32'h00000000);
        chk("fallthrough_paths", rd32(8'h6C), 32'h0000000A);
        chk("jalr_link", rd32(8'h70), 32'h00000098);
        chk("sb_word", rd32(8'h20), 32'h44332278);
        chk("sw_x0", rd32(8'h74), 32'h00000000);
        chk("auipc", rd32(8'h78), 32'h000010B4);
        chk("sll", rd32(8'h7C), 32'h00000020);
        chk("untouched", rd32(8'h80), 32'hAAAAAAAA);
        chk("seen_lb", visited[0], 1);
        chk("seen_lhu", visited[6], 1);
        chk("seen_sb", visited[42], 1);
        chk("seen_ecall", visited[49], 1);
        chk("jal_skip", visited[9], 0);
        chk("beq_skip", visited[26], 0);
        chk("bne_fall", visited[28], 1);
        chk("blt_skip", visited[31], 0);
        chk("bltu_fall", visited[33], 1);
        chk("jalr_skip", visited[38], 0);
        chk("jalr_target", visited[39], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
